// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request/response bundle between the encoder and its producer/consumer.
// Carries the valid/ready request side, the valid/ready result side and the transfer counter.
// master = producer/consumer view, slave = encoder view.
interface imm_encoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_immsrc;
  logic [31:0]      in_imm;
  logic [31:0]      in_base;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;

  modport master (
    output in_valid, in_immsrc, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err, enc_count
  );

  modport slave (
    input  in_valid, in_immsrc, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err, enc_count
  );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: packs a signed immediate into the I/S/B/J fields of an RV32I word over a base word.
// Latency 1 cycle, full rate; in_ready = stage empty | out_ready, output held stable while !out_ready.
// Macro IMMENC_RANGECHK_EN adds a registered out_err for out-of-range or misaligned immediates.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  imm_encoder_if.slave enc_if
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [1:0] SRC_I = 2'b00;
  localparam logic [1:0] SRC_S = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;

  // Scatter immediate bits into the instruction fields; every bit outside the
  // selected field layout comes straight from the base word.
  function automatic logic [31:0] encode(input logic [31:0] base,
                                         input logic [31:0] imm,
                                         input logic [1:0]  src);
    logic [31:0] w;
    w = base;
    case (src)
      SRC_I: begin
        w[31:20] = imm[11:0];
      end
      SRC_S: begin
        w[31:25] = imm[11:5];
        w[11:7]  = imm[4:0];
      end
      SRC_B: begin
        w[31]    = imm[12];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
        w[7]     = imm[11];
      end
      default: begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
    endcase
    return w;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  logic             deliver;
  logic [31:0]      enc_word;

  assign enc_word        = encode(enc_if.in_base, enc_if.in_imm, enc_if.in_immsrc);

  // A held word that is leaving this cycle frees the slot, so back-to-back
  // requests see no bubble.
  assign enc_if.in_ready = (state_q == ST_EMPTY) | enc_if.out_ready;
  assign accept          = enc_if.in_valid & enc_if.in_ready;
  assign deliver         = (state_q == ST_FULL) & enc_if.out_ready;

  assign enc_if.out_valid = (state_q == ST_FULL);
  assign enc_if.out_instr = instr_q;
  assign enc_if.enc_count = count_q;

  // Next-state: fill on accept, drain when the consumer takes the word and nothing replaces it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (accept) begin
          state_d = ST_FULL;
        end else if (enc_if.out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output word only changes on accept; it stays frozen under backpressure.
  always_comb begin
    instr_d = instr_q;
    if (accept) instr_d = enc_word;
  end

  // Count completed output transfers; natural wrap at the top of the range.
  always_comb begin
    count_d = count_q;
    if (deliver) count_d = count_q + CNT_W'(1);
  end

  // Pipeline registers; reset drops any held word immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

`ifdef IMMENC_RANGECHK_EN
  // Range/alignment flag for the field that src selects. B/J offsets must be
  // even; the word is still encoded from the truncated bits when flagged.
  function automatic logic range_err(input logic [31:0] imm,
                                     input logic [1:0]  src);
    logic signed [31:0] v;
    logic               bad;
    v = $signed(imm);
    case (src)
      SRC_I, SRC_S: bad = (v < -32'sd2048) || (v > 32'sd2047);
      SRC_B:        bad = (v < -32'sd4096) || (v > 32'sd4094) || imm[0];
      default:      bad = (v < -32'sd1048576) || (v > 32'sd1048574) || imm[0];
    endcase
    return bad;
  endfunction

  logic err_q, err_d;
  logic enc_err;

  assign enc_err        = range_err(enc_if.in_imm, enc_if.in_immsrc);
  assign enc_if.out_err = err_q;

  // Error flag travels with its word.
  always_comb begin
    err_d = err_q;
    if (accept) err_d = enc_err;
  end

  // Error register, cleared with the word on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  // Without range checking the upper immediate bits and B/J bit 0 are simply discarded.
  logic unused_imm_bits;
  assign unused_imm_bits = ^{enc_if.in_imm[31:21], enc_if.in_imm[0]};
  assign enc_if.out_err  = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed vectors plus randomized traffic for imm_encoder.
// Expected words come from field masks and an independent RV32I immediate decoder.
// Random phase scoreboards accepted requests against delivered words and the counter.
module tb_imm_encoder;
  localparam int CNT_W = 16;

`ifdef IMMENC_RANGECHK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
  } req_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [CNT_W-1:0] exp_count;

  imm_encoder_if #(.CNT_W(CNT_W)) bus ();

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enc_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32I immediate extender: the inverse view used to judge the encoder.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] src);
    case (src)
      2'b00:   return {{20{w[31]}}, w[31:20]};
      2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
      2'b10:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  // What extend() must return: the immediate truncated to the field width, bit 0 cleared for B/J.
  function automatic logic [31:0] exp_ext(input logic [31:0] imm, input logic [1:0] src);
    int t;
    t = int'(imm);
    case (src)
      2'b00, 2'b01: return 32'((t <<< 20) >>> 20);
      2'b10:        return 32'((t <<< 19) >>> 19) & 32'hFFFF_FFFE;
      default:      return 32'((t <<< 11) >>> 11) & 32'hFFFF_FFFE;
    endcase
  endfunction

  function automatic logic [31:0] field_mask(input logic [1:0] src);
    case (src)
      2'b00:        return 32'hFFF0_0000;
      2'b01, 2'b10: return 32'hFE00_0F80;
      default:      return 32'hFFFF_F000;
    endcase
  endfunction

  function automatic logic exp_err(input logic [31:0] imm, input logic [1:0] src);
    int v;
    logic bad;
    v = int'(imm);
    case (src)
      2'b00, 2'b01: bad = (v < -2048) || (v > 2047);
      2'b10:        bad = (v < -4096) || (v > 4094) || (imm[0] == 1'b1);
      default:      bad = (v < -1048576) || (v > 1048574) || (imm[0] == 1'b1);
    endcase
    return RC && bad;
  endfunction

  task automatic drive_req(input logic v, input logic [1:0] src,
                           input logic [31:0] imm, input logic [31:0] base);
    bus.in_valid  = v;
    bus.in_immsrc = src;
    bus.in_imm    = imm;
    bus.in_base   = base;
  endtask

  // Load one word with the consumer stalled; entry/exit one step after a rising edge.
  task automatic push_one(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base);
    drive_req(1'b1, src, imm, base);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Let the consumer take the held word.
  task automatic pop_one();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_count = exp_count + 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_req(1'b0, 2'b00, 32'h0, 32'h0);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.out_instr); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.out_err); end
    checks++; if (bus.enc_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.enc_count); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    reset = 1'b0;
    exp_count = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    push_one(2'b00, 32'hFFFF_FFFC, 32'h0003_a303);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL vec_i_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'hffc3_a303) begin failures++; $display("FAIL vec_i got=%h exp=ffc3a303", bus.out_instr); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL vec_i_err got=%b exp=0", bus.out_err); end
    pop_one();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL vec_i_drain got=%b exp=0", bus.out_valid); end
    checks++; if (bus.enc_count !== exp_count) begin failures++; $display("FAIL vec_i_count got=%0d exp=%0d", bus.enc_count, exp_count); end

    push_one(2'b01, 32'd8, 32'h01d3_a023);
    checks++; if (bus.out_instr !== 32'h01d3_a423) begin failures++; $display("FAIL vec_s got=%h exp=01d3a423", bus.out_instr); end
    pop_one();

    push_one(2'b10, 32'd28, 32'h000e_8063);
    checks++; if (bus.out_instr !== 32'h000e_8e63) begin failures++; $display("FAIL vec_b got=%h exp=000e8e63", bus.out_instr); end
    pop_one();
    checks++; if (bus.enc_count !== exp_count) begin failures++; $display("FAIL vec_count got=%0d exp=%0d", bus.enc_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] c0;
    c0 = exp_count;
    drive_req(1'b1, 2'b11, 32'd8, 32'h0000_00ef);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    drive_req(1'b1, 2'b11, 32'd20, 32'h0000_006f);
    checks++; if (bus.out_instr !== 32'h0080_00ef) begin failures++; $display("FAIL b2b_first got=%h exp=008000ef", bus.out_instr); end
    checks++; if (bus.enc_count !== c0) begin failures++; $display("FAIL b2b_count0 got=%0d exp=%0d", bus.enc_count, c0); end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid2 got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0140_006f) begin failures++; $display("FAIL b2b_second got=%h exp=0140006f", bus.out_instr); end
    checks++; if (bus.enc_count !== c0 + 16'd1) begin failures++; $display("FAIL b2b_count1 got=%0d exp=%0d", bus.enc_count, c0 + 16'd1); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_count = c0 + 16'd2;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
    checks++; if (bus.enc_count !== exp_count) begin failures++; $display("FAIL b2b_count2 got=%0d exp=%0d", bus.enc_count, exp_count); end
  endtask

  task automatic test_backpressure();
    push_one(2'b00, 32'hFFFF_FFFC, 32'h0003_a303);
    drive_req(1'b1, 2'b01, 32'd8, 32'h01d3_a023);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
      checks++; if (bus.out_instr !== 32'hffc3_a303) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=ffc3a303", i, bus.out_instr); end
      checks++; if (bus.enc_count !== exp_count) begin failures++; $display("FAIL bp_count cyc=%0d got=%0d exp=%0d", i, bus.enc_count, exp_count); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    checks++; if (bus.out_instr !== 32'h01d3_a423) begin failures++; $display("FAIL bp_next got=%h exp=01d3a423", bus.out_instr); end
    checks++; if (bus.enc_count !== exp_count) begin failures++; $display("FAIL bp_count_after got=%0d exp=%0d", bus.enc_count, exp_count); end
    pop_one();
  endtask

  task automatic test_rangechk();
    push_one(2'b10, 32'd29, 32'h000e_8063);
    checks++; if (bus.out_instr !== 32'h000e_8e63) begin failures++; $display("FAIL rc_b_word got=%h exp=000e8e63", bus.out_instr); end
    checks++; if (bus.out_err !== RC) begin failures++; $display("FAIL rc_b_err got=%b exp=%b", bus.out_err, RC); end
    pop_one();
    push_one(2'b00, 32'd2048, 32'h0003_a303);
    checks++; if (bus.out_instr !== 32'h8003_a303) begin failures++; $display("FAIL rc_i_word got=%h exp=8003a303", bus.out_instr); end
    checks++; if (bus.out_err !== RC) begin failures++; $display("FAIL rc_i_err got=%b exp=%b", bus.out_err, RC); end
    pop_one();
    push_one(2'b11, 32'hFFF0_0000, 32'h0000_00ef);
    checks++; if (bus.out_instr !== 32'h8000_00ef) begin failures++; $display("FAIL rc_j_word got=%h exp=800000ef", bus.out_instr); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL rc_j_err got=%b exp=0", bus.out_err); end
    pop_one();
  endtask

  task automatic test_reset_midflight();
    push_one(2'b01, 32'hFFFF_F800, 32'h0000_0023);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_full got=%b exp=1", bus.out_valid); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.enc_count !== 16'd0) begin failures++; $display("FAIL mid_async_count got=%0d exp=0", bus.enc_count); end
    @(negedge clk);
    reset = 1'b0;
    exp_count = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_no_output got=%b exp=0", bus.out_valid); end
    checks++; if (bus.enc_count !== 16'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", bus.enc_count); end
  endtask

  task automatic test_random();
    req_t q[$];
    req_t cur;
    req_t got;
    logic have_req;
    have_req = 1'b0;
    cur = '0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      if (cyc >= 400 && !have_req && q.size() == 0) break;
      if (cyc < 400 && !have_req && $urandom_range(0, 3) != 0) begin
        cur.src  = 2'($urandom_range(0, 3));
        cur.base = $urandom;
        case ($urandom_range(0, 3))
          0: cur.imm = $urandom;
          1: begin
            case (cur.src)
              2'b00, 2'b01: cur.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
              2'b10:        cur.imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
              default:      cur.imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
            endcase
          end
          2: begin
            case (cur.src)
              2'b00, 2'b01: cur.imm = ($urandom_range(0, 1) != 0) ? 32'd2047 : 32'hFFFF_F800;
              2'b10:        cur.imm = ($urandom_range(0, 1) != 0) ? 32'd4094 : 32'hFFFF_F000;
              default:      cur.imm = ($urandom_range(0, 1) != 0) ? 32'd1048574 : 32'hFFF0_0000;
            endcase
            if ($urandom_range(0, 2) == 0) cur.imm = cur.imm + 32'd1;
          end
          default: cur.imm = $urandom & 32'h0000_3FFF;
        endcase
        have_req = 1'b1;
      end
      drive_req(have_req, cur.src, cur.imm, cur.base);
      bus.out_ready = (cyc >= 400) ? 1'b1 : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      checks++; if (bus.out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, q.size() != 0); end
      checks++; if (bus.in_ready !== ((q.size() == 0) || bus.out_ready)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, (q.size() == 0) || bus.out_ready); end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rnd_spurious cyc=%0d got=%h exp=none", cyc, bus.out_instr);
        end else begin
          got = q.pop_front();
          checks++; if ((bus.out_instr & ~field_mask(got.src)) !== (got.base & ~field_mask(got.src))) begin failures++; $display("FAIL rnd_base cyc=%0d src=%0d got=%h exp=%h", cyc, got.src, bus.out_instr & ~field_mask(got.src), got.base & ~field_mask(got.src)); end
          checks++; if (extend(bus.out_instr, got.src) !== exp_ext(got.imm, got.src)) begin failures++; $display("FAIL rnd_roundtrip cyc=%0d src=%0d imm=%h got=%h exp=%h", cyc, got.src, got.imm, extend(bus.out_instr, got.src), exp_ext(got.imm, got.src)); end
          checks++; if (bus.out_err !== exp_err(got.imm, got.src)) begin failures++; $display("FAIL rnd_err cyc=%0d src=%0d imm=%h got=%b exp=%b", cyc, got.src, got.imm, bus.out_err, exp_err(got.imm, got.src)); end
        end
        exp_count = exp_count + 1'b1;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(cur);
        have_req = 1'b0;
      end
      @(posedge clk); #1;
      checks++; if (bus.enc_count !== exp_count) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, bus.enc_count, exp_count); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (q.size() != 0 || have_req) begin failures++; $display("FAIL rnd_drain got=%0d exp=0", q.size()); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_count = '0;
    reset     = 1'b1;
    bus.out_ready = 1'b0;
    drive_req(1'b0, 2'b00, 32'h0, 32'h0);
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_rangechk();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
